// File: rtl/ff_wr_arbiter.sv
// Round-robin write arbiter sharing one W-bit register between N requesters.
// Optional build macro FF_ARB_PRIO_EN gives requester 0 fixed priority over the ring.
module ff_wr_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rest,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         q,
    output logic                 busy,
    output logic [$clog2(N)-1:0] last_id
);

    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;
    logic [IW-1:0] sel;
    logic [N-1:0]  eligible;
    logic [N-1:0]  gnt_nxt;
    logic          any_elig;
    logic          ptr_upd;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        if (idx == IW'(N - 1))
            return '0;
        else
            return idx + IW'(1);
    endfunction

    // Selection: a requester acked this cycle sits out, then scan the ring from ptr.
    always_comb begin
        logic [IW-1:0] cand;
        cand     = '0;
        eligible = req & ~gnt;
        sel      = '0;
        any_elig = 1'b0;
        ptr_upd  = 1'b1;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any_elig && eligible[cand]) begin
                any_elig = 1'b1;
                sel      = cand;
            end
        end
`ifdef FF_ARB_PRIO_EN
        if (eligible[0]) begin
            any_elig = 1'b1;
            sel      = '0;
            ptr_upd  = 1'b0;
        end
`endif
        gnt_nxt = '0;
        if (any_elig)
            gnt_nxt[sel] = 1'b1;
        ptr_nxt = ptr_upd ? wrap_inc(sel) : ptr;
    end

    // Commit stage: only the selected lane is read, so X on other lanes never reaches q.
    always_ff @(posedge clk) begin
        if (rest) begin
            q       <= '0;
            gnt     <= '0;
            last_id <= '0;
            ptr     <= '0;
        end else begin
            gnt <= gnt_nxt;
            if (any_elig) begin
                q       <= wdata[sel*W +: W];
                last_id <= sel;
                ptr     <= ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rest)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_elig)  state_nxt = ACTIVE;
            ACTIVE:  if (!any_elig) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ACTIVE);
    end

endmodule

// File: doc/ff_wr_arbiter.md
Name: ff_wr_arbiter

Overview:
- Round-robin write arbiter that shares one W-bit register, built from the team's D flip-flop cells, between N requesters.
- Each cycle it grants at most one pending requester, loads that requester's data into the shared register, and returns a one-cycle grant/ack.
- Sits between client blocks and the shared register. The register itself is internal; its value is exported on q.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, width of shared register and of each write-data lane

Ports:
- clk  input  1  system clock, rising edge
- rest  input  1  reset; synchronous, active-high
- req  input  N  req[i]=1: requester i wants to write wdata lane i
- wdata  input  N*W  lane i = wdata[i*W +: W]
- gnt  output  N  registered one-hot ack; gnt[i]=1 for exactly one cycle after requester i's write commits
- q  output  W  current value of shared register
- busy  output  1  1 when FSM is in ACTIVE
- last_id  output  $clog2(N)  index of most recently granted requester

Behaviour:
- Reset (rest=1 at rising edge of clk) takes priority over all other activity:
  - q=0, gnt=0, busy=0, last_id=0, ptr=0, state=IDLE.
  - Reset asserted mid-operation drops any in-flight grant. No write occurs on that edge.
- Eligibility: eligible[i] = req[i] & ~gnt[i].
  - A requester acked in the current cycle cannot be re-granted the same cycle.
  - Back-to-back writes by the same requester therefore take at least 2 cycles each.
- Selection (combinational): scan eligible starting at index ptr, wrapping modulo N. The first set bit is sel.
- Commit on the edge where any eligible bit is set:
  - q <= lane sel
  - gnt <= one-hot(sel)
  - last_id <= sel
  - ptr <= (sel+1) mod N; wrap from N-1 to 0.
- No eligible requester on an edge: gnt <= 0; q, ptr and last_id hold.
- Latency: req sampled at edge k. q updated and gnt asserted after edge k, visible in cycle k+1.
- Requester protocol:
  - Hold req and wdata stable until gnt[i] is seen.
  - Deassert req in the same cycle gnt[i] is seen, or keep it high to request another write.
- FSM:
  - IDLE: no eligible requesters. Go to ACTIVE on an edge with any eligible bit set (grant issued on that edge).
  - ACTIVE: stay while any eligible bit is set at the edge. Return to IDLE on an edge with none eligible.
  - busy = (state==ACTIVE).
- Simultaneous requests: exactly one grant per cycle. gnt is never multi-hot.
- Fairness: with all N requesting continuously, each is granted once per N cycles when N>=2.
- Values of wdata lanes not selected are ignored. X on an ungranted lane must not propagate to q.

Optional Feature:
- Macro: FF_ARB_PRIO_EN.
- Defined: requester 0 has fixed priority.
  - If eligible[0]=1, sel=0 regardless of ptr.
  - ptr is not updated on requester-0 grants.
  - Other requesters use round-robin as above.
- Undefined: pure round-robin for all requesters, as in Behaviour.

Test Plan:
- Reset: hold rest=1 for 2 cycles with req=4'b1111 -> q=0, gnt=0, busy=0, last_id=0 throughout. First grant after release goes to requester 0.
- Single requester: req=4'b0100, lane2=8'hA5, held high -> q=8'hA5 and gnt=4'b0100 one cycle after first edge. gnt alternates 0100/0000 each cycle. last_id=2.
- Round-robin wrap: req=4'b1111, lanes = 8'h10, 8'h21, 8'h32, 8'h43 from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001. q tracks 10, 21, 32, 43, 10. ptr wraps from 3 to 0.
- Simultaneous arrival after idle: ptr=3, req=4'b1001 -> grant 3, then 0. busy=1 for two cycles, then 0 after req drops.
- Reset mid-operation: rest=1 on the edge that would grant requester 1 with lane1=8'hFF -> q=0, gnt=0, no ack for requester 1. After release, requester 1 is granted normally.
- FF_ARB_PRIO_EN defined: req=4'b1110 steady, then req[0] raised in cycle 3 -> requester 0 granted at the next edge ahead of the round-robin order. Round-robin among 1..3 resumes where it left off.
